triad_uart_arbiter: RTL
=======================

TRIAD_UART_ARBITER -- requirements
Module: triad_uart_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 102: width of one triad's sensor_iterations record.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 9_600_000: clk_96MHz cycles (100 ms) allowed per SEND or DRAIN phase.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have clk_96MHz, input, 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have data_avl_in, input, 4: bit i high means triad i holds a complete record.
REQ-006 The block SHALL have sensor_iterations_in, input, 4*DATA_W: triad i's record at [DATA_W*i +: DATA_W].
REQ-007 The block SHALL have reset_parser_out, output, 4: one-cycle pulse to triad i releasing its record.
REQ-008 The block SHALL have tx_data_availible, output, 1: request to serial_transmitter.
REQ-009 The block SHALL have tx_sensor_iterations, output, DATA_W: latched record presented to the transmitter.
REQ-010 The block SHALL have tx_triad_id, output, 2: index of the triad owning tx_sensor_iterations.
REQ-011 The block SHALL have tx_reset_parser, input, 1: transmitter completion level, already synchronous to clk_96MHz.
REQ-012 The block SHALL have busy, output, 1: high in every state except IDLE.
REQ-013 The block SHALL have timeout_count, output, 8: saturating count of abandoned transfers.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SEND, DRAIN.
REQ-015 In IDLE, when any data_avl_in bit is high, the block SHALL grant round-robin, highest priority at (last_grant+1) mod 4, searching upward with wrap-around.
REQ-016 In the grant cycle the block SHALL capture the granted record into tx_sensor_iterations, set tx_triad_id and last_grant, clear the phase counter, and enter SEND.
REQ-017 tx_data_availible SHALL be high exactly while in SEND, asserted the cycle after the grant edge; tx_sensor_iterations and tx_triad_id SHALL remain stable until the next grant.
REQ-018 The block SHALL register tx_reset_parser into tx_rp_q every cycle; a rise SHALL be defined as tx_reset_parser=1 and tx_rp_q=0.
REQ-019 In SEND, a rise SHALL pulse reset_parser_out[tx_triad_id] high for exactly one cycle and move to DRAIN; a level already high on entry to SEND SHALL NOT count as a rise.
REQ-020 In SEND, if the phase counter reaches TIMEOUT_CYC-1 with no rise, the block SHALL pulse reset_parser_out[tx_triad_id], increment timeout_count (saturating at 255), and enter DRAIN.
REQ-021 If a rise and timeout occur in the same cycle, the rise SHALL win and timeout_count SHALL NOT increment.
REQ-022 Entering DRAIN SHALL clear the phase counter.
REQ-023 DRAIN SHALL return to IDLE when tx_reset_parser=0 and data_avl_in[tx_triad_id]=0, or when the phase counter reaches TIMEOUT_CYC-1, whichever comes first.
REQ-024 A DRAIN timeout SHALL NOT increment timeout_count and SHALL NOT issue another reset_parser_out pulse.
REQ-025 At most one reset_parser_out bit SHALL be high in any cycle.
REQ-026 data_avl_in changes on non-granted triads during SEND or DRAIN SHALL have no effect until IDLE.
REQ-027 The phase counter SHALL be 24 bits, increment every cycle in SEND and DRAIN, and be held at 0 in IDLE.
REQ-028 IDLE-to-grant latency SHALL be 1 cycle from data_avl_in sampled high to tx_data_availible high.

Reset
REQ-029 While rst_n=0 the block SHALL force: state IDLE, last_grant=3, tx_data_availible=0, tx_sensor_iterations=0, tx_triad_id=0, reset_parser_out=0, busy=0, timeout_count=0, tx_rp_q=0, phase counter=0.
REQ-030 Reset mid-transfer SHALL abort without emitting any reset_parser_out pulse; the first grant after release SHALL favour triad 0.

Verification
REQ-031 The bench SHALL cover: after reset, data_avl_in=4'b1111 -> grants in order 0,1,2,3,0 across successive completed transfers.
REQ-032 The bench SHALL cover: triad 2 only, record 102'h15A; tx_reset_parser rises 40 cycles after the request -> tx_sensor_iterations=102'h15A, tx_triad_id=2, one reset_parser_out=4'b0100 pulse on the cycle after the rise, busy falls after tx_reset_parser and data_avl_in[2] are both low.
REQ-033 The bench SHALL cover: TIMEOUT_CYC=16, tx_reset_parser held 0 -> reset_parser_out pulse after 16 SEND cycles, timeout_count=1; repeat 300 times -> timeout_count=255.
REQ-034 The bench SHALL cover: tx_reset_parser already high on entry to SEND -> no pulse until it falls and rises again.
REQ-035 The bench SHALL cover: rst_n asserted during SEND -> all outputs 0 immediately, no reset_parser_out pulse; after release with 4'b1010 pending -> triad 1 granted first.

Source files
------------

// File: rtl/triad_uart_arbiter.sv
// Round-robin arbiter handing completed triad records to a single UART transmitter.
// Each transfer is bounded by a SEND and a DRAIN watchdog phase.
module triad_uart_arbiter #(
    parameter int DATA_W      = 102,
    parameter int TIMEOUT_CYC = 9_600_000
) (
    input  logic                  clk_96MHz,
    input  logic                  rst_n,
    input  logic [3:0]            data_avl_in,
    input  logic [4*DATA_W-1:0]   sensor_iterations_in,
    output logic [3:0]            reset_parser_out,
    output logic                  tx_data_availible,
    output logic [DATA_W-1:0]     tx_sensor_iterations,
    output logic [1:0]            tx_triad_id,
    input  logic                  tx_reset_parser,
    output logic                  busy,
    output logic [7:0]            timeout_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [23:0] LP_LAST = 24'(TIMEOUT_CYC - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_last;
    logic [1:0]        r_id;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        r_rpo;
    logic [7:0]        r_tcnt;
    logic              r_tx_rp_q;
    logic [23:0]       r_phase;

    logic              w_any;
    logic              w_hit;
    logic [1:0]        w_idx;
    logic [1:0]        w_gnt;
    logic [DATA_W-1:0] w_rec;
    logic              w_rise;
    logic              w_last;
    logic [3:0]        w_id_hot;

    assign w_any    = |data_avl_in;
    assign w_rise   = tx_reset_parser & ~r_tx_rp_q;
    assign w_last   = (r_phase == LP_LAST);
    assign w_id_hot = 4'b0001 << r_id;

    // Search upward from the triad after the last grant, wrapping round.
    always_comb begin
        w_gnt = r_last;
        w_hit = 1'b0;
        w_idx = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_hit && data_avl_in[w_idx]) begin
                w_gnt = w_idx;
                w_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_rec = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_gnt == 2'(i))
                w_rec = sensor_iterations_in[DATA_W*i +: DATA_W];
        end
    end

    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last    <= 2'd3;
            r_id      <= 2'd0;
            r_data    <= '0;
            r_rpo     <= 4'd0;
            r_tcnt    <= 8'd0;
            r_tx_rp_q <= 1'b0;
            r_phase   <= 24'd0;
        end else begin
            r_tx_rp_q <= tx_reset_parser;
            r_rpo     <= 4'd0;
            unique case (r_state)
                IDLE: begin
                    r_phase <= 24'd0;
                    if (w_any) begin
                        r_data  <= w_rec;
                        r_id    <= w_gnt;
                        r_last  <= w_gnt;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_rise) begin
                        r_rpo   <= w_id_hot;
                        r_phase <= 24'd0;
                        r_state <= DRAIN;
                    end else if (w_last) begin
                        r_rpo   <= w_id_hot;
                        r_phase <= 24'd0;
                        r_state <= DRAIN;
                        if (r_tcnt != 8'hFF)
                            r_tcnt <= r_tcnt + 8'd1;
                    end else begin
                        r_phase <= r_phase + 24'd1;
                    end
                end
                DRAIN: begin
                    // Wait for the transmitter and the triad to both let go.
                    if ((!tx_reset_parser && !data_avl_in[r_id]) || w_last) begin
                        r_phase <= 24'd0;
                        r_state <= IDLE;
                    end else begin
                        r_phase <= r_phase + 24'd1;
                    end
                end
                default: begin
                    r_phase <= 24'd0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign reset_parser_out     = r_rpo;
    assign tx_data_availible    = (r_state == SEND);
    assign tx_sensor_iterations = r_data;
    assign tx_triad_id          = r_id;
    assign busy                 = (r_state != IDLE);
    assign timeout_count        = r_tcnt;

endmodule
